// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: walks (m,n,k) 4x4 tile loops of C=AxB, driving the 4x4 matmul engine per tile op.
// Ports: job_* descriptor handshake in; mm_* engine control/addresses out, mm_done in;
//        abort requests early stop; busy/job_done/job_err/ops_issued report job status.
module matmul_tile_scheduler #(
  parameter int ADDR_W = 10,
  parameter int STRIDE_W = 8,
  parameter int CNT_W = 4,
  parameter int TILE_WORDS = 4,
  parameter int OPS_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [ADDR_W-1:0]   job_a_base,
  input  logic [ADDR_W-1:0]   job_b_base,
  input  logic [ADDR_W-1:0]   job_c_base,
  input  logic [CNT_W-1:0]    job_m_tiles,
  input  logic [CNT_W-1:0]    job_n_tiles,
  input  logic [CNT_W-1:0]    job_k_tiles,
  input  logic                job_is_fp8,
  input  logic                abort,
  output logic                mm_start,
  input  logic                mm_done,
  output logic                mm_pe_resetn,
  output logic                mm_is_fp8,
  output logic [ADDR_W-1:0]   mm_addr_a,
  output logic [ADDR_W-1:0]   mm_addr_b,
  output logic [ADDR_W-1:0]   mm_addr_c,
  output logic [STRIDE_W-1:0] mm_stride_a,
  output logic [STRIDE_W-1:0] mm_stride_b,
  output logic [STRIDE_W-1:0] mm_stride_c,
  output logic                busy,
  output logic                job_done,
  output logic                job_err,
  output logic [OPS_W-1:0]    ops_issued
);
  typedef enum logic [2:0] {S_IDLE, S_PRST, S_ISSUE, S_WAIT, S_REL, S_FIN} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_a_base, r_b_base, r_c_base, r_addr_a, r_addr_b, r_addr_c;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b, w_addr_c;
  logic [CNT_W-1:0] r_m_t, r_n_t, r_k_t, r_m, r_n, r_k, w_m_nx, w_n_nx, w_k_nx;
  logic [OPS_W-1:0] r_ops;
  logic r_fp8, r_err, r_abort;
  logic w_accept, w_zero, w_k_wrap, w_n_wrap, w_m_wrap, w_last, w_abort, w_rel_go;
  assign job_ready = (r_state == S_IDLE) & ~reset;
  assign mm_pe_resetn = ~reset & (r_state != S_PRST);
  assign mm_start = (r_state == S_ISSUE) | (r_state == S_WAIT);
  assign busy = r_state != S_IDLE;
  assign job_done = r_state == S_FIN;
  assign job_err = (r_state == S_FIN) & r_err;
  assign mm_is_fp8 = r_fp8;
  assign mm_addr_a = r_addr_a;
  assign mm_addr_b = r_addr_b;
  assign mm_addr_c = r_addr_c;
  assign mm_stride_a = STRIDE_W'(1);
  assign mm_stride_b = STRIDE_W'(1);
  assign mm_stride_c = STRIDE_W'(1);
  assign ops_issued = r_ops;
  assign w_accept = job_valid & job_ready;
  assign w_zero = (job_m_tiles == '0) | (job_n_tiles == '0) | (job_k_tiles == '0);
  assign w_k_wrap = r_k == r_k_t - CNT_W'(1);
  assign w_n_wrap = r_n == r_n_t - CNT_W'(1);
  assign w_m_wrap = r_m == r_m_t - CNT_W'(1);
  assign w_last = w_k_wrap & w_n_wrap & w_m_wrap;
  assign w_k_nx = w_k_wrap ? '0 : r_k + CNT_W'(1);
  assign w_n_nx = w_k_wrap ? (w_n_wrap ? '0 : r_n + CNT_W'(1)) : r_n;
  assign w_m_nx = (w_k_wrap & w_n_wrap) ? r_m + CNT_W'(1) : r_m;
  // abort raised in the decision cycle itself is honoured as well
  assign w_abort = r_abort | abort;
  assign w_rel_go = (r_state == S_REL) & ~mm_done;
  // addresses are computed from the next indices so they are already valid when ISSUE is entered
  assign w_addr_a = r_a_base + ADDR_W'(TILE_WORDS) * (ADDR_W'(w_m_nx) * ADDR_W'(r_k_t) + ADDR_W'(w_k_nx));
  assign w_addr_b = r_b_base + ADDR_W'(TILE_WORDS) * (ADDR_W'(w_k_nx) * ADDR_W'(r_n_t) + ADDR_W'(w_n_nx));
  assign w_addr_c = r_c_base + ADDR_W'(TILE_WORDS) * (ADDR_W'(w_m_nx) * ADDR_W'(r_n_t) + ADDR_W'(w_n_nx));
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_accept ? (w_zero ? S_FIN : S_PRST) : S_IDLE;
      S_PRST:  w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = mm_done ? S_REL : S_WAIT;
      S_REL:   w_next = ~w_rel_go ? S_REL : (w_last | w_abort) ? S_FIN : (w_k_nx == '0) ? S_PRST : S_ISSUE;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      {r_a_base, r_b_base, r_c_base, r_addr_a, r_addr_b, r_addr_c} <= '0;
      {r_m_t, r_n_t, r_k_t, r_m, r_n, r_k} <= '0;
      r_ops <= '0;
      {r_fp8, r_err, r_abort} <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        {r_a_base, r_b_base, r_c_base} <= {job_a_base, job_b_base, job_c_base};
        {r_addr_a, r_addr_b, r_addr_c} <= {job_a_base, job_b_base, job_c_base};
        {r_m_t, r_n_t, r_k_t} <= {job_m_tiles, job_n_tiles, job_k_tiles};
        {r_m, r_n, r_k} <= '0;
        r_fp8 <= job_is_fp8;
        r_err <= w_zero;
        r_abort <= 1'b0;
        r_ops <= '0;
      end else begin
        r_abort <= (r_state == S_FIN) ? 1'b0 : r_abort | (busy & abort);
        if ((r_state == S_WAIT) & mm_done) r_ops <= r_ops + OPS_W'(1);
        if (w_rel_go & ~w_last & w_abort) r_err <= 1'b1;
        if (w_rel_go & ~w_last & ~w_abort) begin
          {r_m, r_n, r_k} <= {w_m_nx, w_n_nx, w_k_nx};
          {r_addr_a, r_addr_b, r_addr_c} <= {w_addr_a, w_addr_b, w_addr_c};
        end
      end
    end
  end
endmodule

// File: doc/matmul_tile_scheduler.md
Name: matmul_tile_scheduler

Overview:
Sequences the 4x4 matrix_multiplication engine over a larger tiled matrix product C[M][N] = A[M][K] x B[K][N]. Tile counts are given in units of 4x4 tiles. The block accepts one job descriptor through a valid/ready handshake. It walks the (m, n, k) tile loops, driving the engine's start, pe_resetn, is_fp8, address and stride inputs. PEs accumulate across k, and pe_resetn is pulsed only at the start of each output tile.

Parameters:
ADDR_W, 10, address width of A/B/C memories and tile base inputs
STRIDE_W, 8, width of engine stride outputs
CNT_W, 4, width of each tile-count field (max 15 tiles per dimension)
TILE_WORDS, 4, memory words occupied by one 4x4 tile
OPS_W, 12, width of ops_issued counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
job_valid  in  1  descriptor valid
job_ready  out  1  scheduler can accept descriptor (high only in IDLE)
job_a_base  in  ADDR_W  base word address of A tiles
job_b_base  in  ADDR_W  base word address of B tiles
job_c_base  in  ADDR_W  base word address of C tiles
job_m_tiles  in  CNT_W  row tiles M
job_n_tiles  in  CNT_W  column tiles N
job_k_tiles  in  CNT_W  inner tiles K
job_is_fp8  in  1  1 = fp8 mode, 0 = int8 mode
abort  in  1  request early termination
mm_start  out  1  engine start, level
mm_done  in  1  engine done, level
mm_pe_resetn  out  1  engine PE reset, active low
mm_is_fp8  out  1  engine mode
mm_addr_a, mm_addr_b, mm_addr_c  out  ADDR_W  engine tile addresses
mm_stride_a, mm_stride_b, mm_stride_c  out  STRIDE_W  constant 1
busy  out  1  high in any state except IDLE
job_done  out  1  one-cycle pulse at job end
job_err  out  1  one-cycle pulse coincident with job_done on zero-count or abort
ops_issued  out  OPS_W  engine operations completed in current/last job

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset.
- Reset values:
  - State = IDLE.
  - mm_start=0, mm_pe_resetn=0 while reset is high, mm_is_fp8=0.
  - All addresses 0; strides always 1.
  - busy=0, job_done=0, job_err=0, ops_issued=0.
  - job_ready=0 during reset, 1 in the first cycle after.
- Reset mid-job: next cycle is IDLE with mm_start=0. The job is dropped with no job_done.
- Descriptor latching: all descriptor fields are latched on accept (job_valid & job_ready). The inputs are don't-care afterwards. ops_issued clears to 0 on accept.
- States:
  - IDLE:
    - job_ready=1, mm_pe_resetn=1.
    - On accept: if any count is 0 -> FINISH with err flag set. Otherwise m=n=k=0 -> PRST.
  - PRST: mm_pe_resetn=0 for exactly one cycle -> ISSUE.
  - ISSUE: mm_start=1 with addresses/mode valid in the same cycle -> WAIT.
  - WAIT:
    - mm_start stays 1.
    - On mm_done=1: ops_issued++ -> RELEASE.
  - RELEASE:
    - mm_start=0; stay until mm_done=0.
    - Then advance in order: k++. On k wrap, k=0 and n++. On n wrap, n=0 and m++.
    - If m wraps -> FINISH.
    - Else if abort_pending -> FINISH with err.
    - Else if new k==0 -> PRST, otherwise ISSUE.
  - FINISH: job_done=1 (job_err if flagged) for one cycle -> IDLE.
- Address computation:
  - mm_addr_a = a_base + TILE_WORDS*(m*K + k)
  - mm_addr_b = b_base + TILE_WORDS*(k*N + n)
  - mm_addr_c = c_base + TILE_WORDS*(m*N + n)
  - Computed modulo 2^ADDR_W (wrap, no error).
  - Registered; stable from ISSUE through RELEASE.
- abort:
  - Sampled every cycle while busy and sets a sticky abort_pending. Ignored in IDLE.
  - Never truncates an in-flight op; honoured only at the RELEASE decision.
  - abort_pending clears at FINISH.
- Simultaneous events: abort together with the final op's RELEASE -> normal completion, job_err=0.
- mm_done held high: start is never re-raised until mm_done has been observed low.

Test Plan:
1. Single tile, int8, bases 0/0/0, M=N=K=1 -> one PRST pulse, mm_start high until mm_done, addrs 0/0/0, job_done 1 cycle after mm_done falls + RELEASE, ops_issued=1, job_err=0.
2. M=2, N=1, K=2, a=0x000, b=0x100, c=0x200 -> (a,b,c) sequence (0x000,0x100,0x200), (0x004,0x104,0x200), (0x008,0x100,0x204), (0x00C,0x104,0x204); PRST before ops 1 and 3 only; ops_issued=4.
3. job_k_tiles=0 -> no mm_start, FINISH cycle after accept with job_done=job_err=1, ops_issued=0.
4. M=N=1, K=4, abort pulsed during op 2's WAIT -> op 2 completes, no op 3, job_done+job_err, ops_issued=2.
5. reset asserted during WAIT -> next cycle mm_start=0, busy=0, job_ready=1, no job_done pulse; subsequent job runs normally.
6. fp8 job with a_base=0x3FC, K=2 while job_valid held high -> mm_is_fp8=1, second addr_a=0x000 (wrap), job_ready=0 while busy, second job accepted the cycle after job_done.
